morse_sample_ctrl: RTL and testbench

MORSE_SAMPLE_CTRL -- requirements
Module: morse_sample_ctrl

---
 rtl/morse_pkg.sv | 34 +++
 rtl/morse_tick_gen.sv | 36 +++
 rtl/morse_sample_ctrl.sv | 119 +++++++++++
 tb/tb_morse_sample_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse key sampling controller: FSM encoding,
// symbol codes used by the downstream input processor, and the drain length.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SYM_DOT   = 2'b00,
    SYM_DASH  = 2'b01,
    SYM_NONE  = 2'b10,
    SYM_SPACE = 2'b11
  } symbol_t;

  localparam int DRAIN_TICKS = 3;
  localparam int DRAIN_W     = 2;

  // A 1 sample breaks the silence run; zero samples count up and stick at 15.
  function automatic logic [3:0] zeroRunNext(input logic [3:0] cur, input logic bitIn);
    logic [3:0] nxt;
    if (bitIn) begin
      nxt = 4'd0;
    end else if (cur == 4'hF) begin
      nxt = 4'hF;
    end else begin
      nxt = cur + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Unit divider: free-runs while 'run' is high and flags the last cycle of each
// Morse unit; loading half a unit centres the samples inside each key unit.
module morse_tick_gen #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic load_half,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(TICK_DIV / 2);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load_half) begin
      r_count <= HALF;
    end else if (!run) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // Combinational so the controller can register the strobe and the sampled bit together.
  assign tick = run && (r_count == LAST);

endmodule

// File: rtl/morse_sample_ctrl.sv
// Samples a debounced Morse key once per unit, marks word ends after a run of
// silent units, and drains with a short space when capture is disabled.
module morse_sample_ctrl
  import morse_pkg::*;
#(
  parameter int TICK_DIV   = 5_000_000,
  parameter int IDLE_UNITS = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  input  logic enable,
  output logic sample_tick,
  output logic serial_out,
  output logic word_gap,
  output logic busy
);

  localparam logic [3:0]         GAP_COUNT = 4'(IDLE_UNITS);
  localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(DRAIN_TICKS);

  state_t             r_state;
  logic [3:0]         r_zeroRun;
  logic [DRAIN_W-1:0] r_drainCnt;
  logic               r_sampleTick;
  logic               r_serialOut;
  logic               r_wordGap;
  logic               r_busy;

  logic       w_tick;
  logic       w_run;
  logic       w_loadHalf;
  logic [3:0] w_zeroNext;
  logic       w_gapHit;

  assign w_run      = (r_state != ST_IDLE);
  assign w_loadHalf = (r_state == ST_IDLE) && enable && key_in;
  assign w_zeroNext = zeroRunNext(r_zeroRun, key_in);
  assign w_gapHit   = w_tick && (w_zeroNext == GAP_COUNT);

  morse_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tickGen (
    .clk       (clk),
    .rst       (rst),
    .run       (w_run),
    .load_half (w_loadHalf),
    .tick      (w_tick)
  );

  // A word-gap tick holds the FSM in RUN for one more cycle, so it beats a coincident enable drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_zeroRun    <= 4'd0;
      r_drainCnt   <= '0;
      r_sampleTick <= 1'b0;
      r_serialOut  <= 1'b0;
      r_wordGap    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_sampleTick <= 1'b0;
      r_wordGap    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_serialOut <= 1'b0;
          r_zeroRun   <= 4'd0;
          r_drainCnt  <= '0;
          if (enable && key_in) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (r_wordGap) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_serialOut <= 1'b0;
            r_zeroRun   <= 4'd0;
            r_drainCnt  <= '0;
          end else begin
            if (w_tick) begin
              r_sampleTick <= 1'b1;
              r_serialOut  <= key_in;
              r_zeroRun    <= w_zeroNext;
              r_wordGap    <= w_gapHit;
            end
            if (!enable && !w_gapHit) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (r_drainCnt == DRAIN_END) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_serialOut <= 1'b0;
            r_zeroRun   <= 4'd0;
            r_drainCnt  <= '0;
          end else if (w_tick) begin
            r_sampleTick <= 1'b1;
            r_serialOut  <= 1'b0;
            r_drainCnt   <= r_drainCnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sample_tick = r_sampleTick;
  assign serial_out  = r_serialOut;
  assign word_gap    = r_wordGap;
  assign busy        = r_busy;

endmodule

// File: tb/tb_morse_sample_ctrl.sv
// Directed bench for morse_sample_ctrl with TICK_DIV = 4, IDLE_UNITS = 7;
// a scoreboard of expected ticks (cycle, bit, gap) is checked by a monitor.
module tb_morse_sample_ctrl;

  logic clk;
  logic rst;
  logic key_in;
  logic enable;
  logic sample_tick;
  logic serial_out;
  logic word_gap;
  logic busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit monOn  = 1'b0;

  typedef struct {
    int   cycle;
    logic ser;
    logic gap;
  } exp_t;

  exp_t sbq[$];

  morse_sample_ctrl #(
    .TICK_DIV   (4),
    .IDLE_UNITS (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .enable      (enable),
    .sample_tick (sample_tick),
    .serial_out  (serial_out),
    .word_gap    (word_gap),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive inputs on the falling edge so that rising edge number 'edgeNum' samples them.
  task automatic applyStimulus(input int edgeNum, input logic k, input logic en, input logic r);
    while (cyc < edgeNum - 1) @(negedge clk);
    key_in = k;
    enable = en;
    rst    = r;
  endtask

  task automatic waitEdge(input int edgeNum);
    while (cyc < edgeNum) @(negedge clk);
  endtask

  task automatic pushTick(input int c, input logic s, input logic g);
    exp_t x;
    x.cycle = c;
    x.ser   = s;
    x.gap   = g;
    sbq.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (monOn) begin
      if (sample_tick) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_tick", 32'(sample_tick), 32'd0);
        end else begin
          x = sbq.pop_front();
          checkOutput("tick_cycle", cyc, x.cycle);
          checkOutput("tick_serial", 32'(serial_out), 32'(x.ser));
          checkOutput("tick_gap", 32'(word_gap), 32'(x.gap));
        end
      end else if (word_gap) begin
        checkOutput("gap_without_tick", 32'(word_gap), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e;
    rst    = 1'b1;
    key_in = 1'b0;
    enable = 1'b1;

    // Scenario 1: reset state, then 20 idle cycles with no ticks
    waitEdge(3);
    checkOutput("rst_sample_tick", 32'(sample_tick), 32'd0);
    checkOutput("rst_serial_out", 32'(serial_out), 32'd0);
    checkOutput("rst_word_gap", 32'(word_gap), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    monOn = 1'b1;
    applyStimulus(5, 1'b0, 1'b1, 1'b0);
    waitEdge(25);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Scenario 2: first-tick latency with key held
    e = cyc + 3;
    applyStimulus(e, 1'b1, 1'b1, 1'b0);
    pushTick(e + 2, 1'b1, 1'b0);
    pushTick(e + 6, 1'b1, 1'b0);
    pushTick(e + 10, 1'b1, 1'b0);
    waitEdge(e);
    checkOutput("s2_busy_start", 32'(busy), 32'd1);
    waitEdge(e + 11);
    checkOutput("s2_queue", sbq.size(), 32'd0);
    applyStimulus(e + 12, 1'b0, 1'b1, 1'b1);
    waitEdge(e + 12);
    checkOutput("s2_rst_busy", 32'(busy), 32'd0);
    checkOutput("s2_rst_serial", 32'(serial_out), 32'd0);
    applyStimulus(e + 14, 1'b0, 1'b1, 1'b0);

    // Scenario 3: one-unit press, then seven silent units end the word
    e = cyc + 3;
    applyStimulus(e, 1'b1, 1'b1, 1'b0);
    pushTick(e + 2, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) pushTick(e + 6 + 4 * k, 1'b0, (k == 6));
    applyStimulus(e + 3, 1'b0, 1'b1, 1'b0);
    waitEdge(e + 30);
    checkOutput("s3_busy_at_gap", 32'(busy), 32'd1);
    waitEdge(e + 31);
    checkOutput("s3_busy_after", 32'(busy), 32'd0);
    checkOutput("s3_serial_after", 32'(serial_out), 32'd0);
    waitEdge(e + 40);
    checkOutput("s3_queue", sbq.size(), 32'd0);

    // Scenario 4: enable dropped mid-RUN with key pressed drains three zero ticks
    e = cyc + 3;
    applyStimulus(e, 1'b1, 1'b1, 1'b0);
    pushTick(e + 2, 1'b1, 1'b0);
    pushTick(e + 6, 1'b1, 1'b0);
    pushTick(e + 10, 1'b0, 1'b0);
    pushTick(e + 14, 1'b0, 1'b0);
    pushTick(e + 18, 1'b0, 1'b0);
    applyStimulus(e + 7, 1'b1, 1'b0, 1'b0);
    waitEdge(e + 18);
    checkOutput("s4_busy_last_tick", 32'(busy), 32'd1);
    waitEdge(e + 19);
    checkOutput("s4_busy_after", 32'(busy), 32'd0);
    waitEdge(e + 30);
    checkOutput("s4_queue", sbq.size(), 32'd0);
    applyStimulus(e + 31, 1'b0, 1'b1, 1'b0);

    // Scenario 5: enable drop coincides with the word-gap tick
    e = cyc + 3;
    applyStimulus(e, 1'b1, 1'b1, 1'b0);
    pushTick(e + 2, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) pushTick(e + 6 + 4 * k, 1'b0, (k == 6));
    applyStimulus(e + 3, 1'b0, 1'b1, 1'b0);
    applyStimulus(e + 30, 1'b0, 1'b0, 1'b0);
    waitEdge(e + 31);
    checkOutput("s5_busy_after", 32'(busy), 32'd0);
    waitEdge(e + 42);
    checkOutput("s5_busy_idle", 32'(busy), 32'd0);
    checkOutput("s5_queue", sbq.size(), 32'd0);
    applyStimulus(e + 43, 1'b0, 1'b1, 1'b0);

    // Scenario 6: reset right after the first DRAIN tick
    e = cyc + 3;
    applyStimulus(e, 1'b1, 1'b1, 1'b0);
    pushTick(e + 2, 1'b1, 1'b0);
    pushTick(e + 6, 1'b0, 1'b0);
    applyStimulus(e + 3, 1'b1, 1'b0, 1'b0);
    applyStimulus(e + 7, 1'b1, 1'b0, 1'b1);
    waitEdge(e + 7);
    checkOutput("s6_busy_rst", 32'(busy), 32'd0);
    checkOutput("s6_tick_rst", 32'(sample_tick), 32'd0);
    checkOutput("s6_serial_rst", 32'(serial_out), 32'd0);
    applyStimulus(e + 9, 1'b0, 1'b1, 1'b0);
    waitEdge(e + 25);
    checkOutput("s6_busy_end", 32'(busy), 32'd0);
    checkOutput("final_queue", sbq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
